sync_ptr_cdc: RTL and testbench

- Parametrised successor to the two-flop gray pointer synchroniser used in the async FIFO.
- Brings a gray-coded pointer from a foreign clock domain into the rclk domain through a configurable-depth flop chain.
- Also provides: registered gray-to-binary conversion, a one-cycle update strobe, a modular delta since the last update, and an optional gray-integrity monitor.
- Instantiated on both the read side (write pointer) and the write side (read pointer) of the async FIFO.

---
 rtl/sync_ptr_cdc_if.sv | 33 +++
 rtl/sync_ptr_cdc.sv | 114 +++++++++++
 tb/tb_sync_ptr_cdc.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_ptr_cdc_if.sv
// Pointer-crossing bundle for sync_ptr_cdc: the foreign gray pointer in,
// the synchronised gray/binary pointer, update strobe, delta and integrity flag out.
interface sync_ptr_cdc_if #(
    parameter int ASIZE = 4
);
    logic [ASIZE:0] ptr_gray_in;
    logic           err_clr;
    logic [ASIZE:0] ptr_gray_sync;
    logic [ASIZE:0] ptr_bin_sync;
    logic           ptr_upd;
    logic [ASIZE:0] ptr_delta;
    logic           ptr_err;

    modport master (
        output ptr_gray_in,
        output err_clr,
        input  ptr_gray_sync,
        input  ptr_bin_sync,
        input  ptr_upd,
        input  ptr_delta,
        input  ptr_err
    );

    modport slave (
        input  ptr_gray_in,
        input  err_clr,
        output ptr_gray_sync,
        output ptr_bin_sync,
        output ptr_upd,
        output ptr_delta,
        output ptr_err
    );
endinterface

// File: rtl/sync_ptr_cdc.sv
// Gray pointer synchroniser into rclk: STAGES-deep flop chain, registered binary
// conversion, update strobe and modular delta. Define SYNC_PTR_ERR_EN for the gray-integrity monitor.
module sync_ptr_cdc #(
    parameter int ASIZE  = 4,
    parameter int STAGES = 2
) (
    input  logic          rclk,
    input  logic          rrst,
    sync_ptr_cdc_if.slave bus
);
    localparam int PW  = ASIZE + 1;
    localparam int NST = (STAGES < 2) ? 2 : STAGES;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] sync_p0 [NST];
    logic [PW-1:0] gray_sync;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] bin_p1;
    logic          upd_p1;
    logic [PW-1:0] delta_p1;

    // Synchroniser chain: only sync_p0[0] sees the asynchronous input.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < NST; i++) begin
                sync_p0[i] <= '0;
            end
        end else begin
            sync_p0[0] <= bus.ptr_gray_in;
            for (int i = 1; i < NST; i++) begin
                sync_p0[i] <= sync_p0[i-1];
            end
        end
    end

    assign gray_sync = sync_p0[NST-1];
    assign bin_next  = gray2bin(gray_sync);

    // Binary stage: delta keeps its last value between updates.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            bin_p1   <= '0;
            upd_p1   <= 1'b0;
            delta_p1 <= '0;
        end else begin
            bin_p1 <= bin_next;
            upd_p1 <= (bin_next != bin_p1);
            if (bin_next != bin_p1) begin
                delta_p1 <= bin_next - bin_p1;
            end
        end
    end

    assign bus.ptr_gray_sync = gray_sync;
    assign bus.ptr_bin_sync  = bin_p1;
    assign bus.ptr_upd       = upd_p1;
    assign bus.ptr_delta     = delta_p1;

`ifdef SYNC_PTR_ERR_EN
    localparam int ARM_MAX = NST + 1;
    localparam int AW      = $clog2(ARM_MAX + 1);

    function automatic int popcount(input logic [PW-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < PW; i++) begin
            cnt += int'(v[i]);
        end
        return cnt;
    endfunction

    logic [AW-1:0] arm_cnt;
    logic [PW-1:0] prev_gray;
    logic          err_q;
    logic          armed;
    logic          multi_bit;

    assign armed     = (arm_cnt == AW'(ARM_MAX));
    assign multi_bit = (popcount(gray_sync ^ prev_gray) > 1);

    // Monitor stays blind until the chain has refilled after reset.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            arm_cnt   <= '0;
            prev_gray <= '0;
            err_q     <= 1'b0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            prev_gray <= gray_sync;
            if (armed && multi_bit) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.ptr_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.ptr_err    = 1'b0;
`endif
endmodule

// File: tb/tb_sync_ptr_cdc.sv
// Randomised and directed bench for sync_ptr_cdc: STAGES=2 and STAGES=3 instances
// share one input and are checked against a history-based reference model.
module tb_sync_ptr_cdc;
    localparam int PW = 5;
`ifdef SYNC_PTR_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [PW-1:0] gin = '0;
    logic eclr = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sync_ptr_cdc_if #(.ASIZE(4)) b2 ();
    sync_ptr_cdc_if #(.ASIZE(4)) b3 ();
    assign b2.ptr_gray_in = gin;
    assign b3.ptr_gray_in = gin;
    assign b2.err_clr     = eclr;
    assign b3.err_clr     = eclr;

    sync_ptr_cdc #(.ASIZE(4), .STAGES(2)) u2 (.rclk(clk), .rrst(rst), .bus(b2));
    sync_ptr_cdc #(.ASIZE(4), .STAGES(3)) u3 (.rclk(clk), .rrst(rst), .bus(b3));

    function automatic logic [PW-1:0] gray(input int n);
        logic [PW-1:0] v;
        v = PW'(n);
        return v ^ (v >> 1);
    endfunction

    // gray -> binary as the xor of all right shifts of the gray word
    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int s = 1; s < PW; s++) b = b ^ (g >> s);
        return b;
    endfunction

    // Reference model: hist[j] is the input sampled j+1 edges ago (0 = latest edge).
    logic [PW-1:0] hist [8];
    logic [PW-1:0] m_delta [2];
    logic          m_err [2];
    int            edges;

    always @(posedge clk or posedge rst) begin : model
        logic [PW-1:0] nh [8];
        int n;
        if (rst) begin
            for (int i = 0; i < 8; i++) hist[i] <= '0;
            for (int k = 0; k < 2; k++) begin
                m_delta[k] <= '0;
                m_err[k]   <= 1'b0;
            end
            edges <= 0;
        end else begin
            nh[0] = gin;
            for (int i = 1; i < 8; i++) nh[i] = hist[i-1];
            for (int k = 0; k < 2; k++) begin
                n = k + 2;
                if (ERR_EN && edges >= n + 1 && $countones(hist[n-1] ^ hist[n]) > 1)
                    m_err[k] <= 1'b1;
                else if (ERR_EN && eclr)
                    m_err[k] <= 1'b0;
                if (g2b(nh[n]) != g2b(nh[n+1]))
                    m_delta[k] <= g2b(nh[n]) - g2b(nh[n+1]);
            end
            for (int i = 0; i < 8; i++) hist[i] <= nh[i];
            if (edges < 100) edges <= edges + 1;
        end
    end

    function automatic logic [16:0] exp_vec(input int k);
        int n;
        n = k + 2;
        return {hist[n-1], g2b(hist[n]), (g2b(hist[n]) != g2b(hist[n+1])), m_delta[k], m_err[k]};
    endfunction

    function automatic logic [16:0] obs_vec(input int k);
        if (k == 0)
            return {b2.ptr_gray_sync, b2.ptr_bin_sync, b2.ptr_upd, b2.ptr_delta, b2.ptr_err};
        return {b3.ptr_gray_sync, b3.ptr_bin_sync, b3.ptr_upd, b3.ptr_delta, b3.ptr_err};
    endfunction

    task automatic test_reset();
        rst = 1'b1; gin = '0; eclr = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_vec(k) !== 17'd0) begin
                bad++; $display("FAIL reset_hold u%0d got %h want 0", k + 2, obs_vec(k));
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_vec(k) !== 17'd0 || obs_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL reset_static u%0d cyc%0d got %h want %h", k + 2, c, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_static();
        int upds [2];
        upds = '{0, 0};
        gin = gray(1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL static u%0d cyc%0d got %h want %h", k + 2, c, obs_vec(k), exp_vec(k));
                end
                upds[k] += int'(obs_vec(k)[6]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (upds[k] != 1 || obs_vec(k)[11:7] !== 5'd1 || obs_vec(k)[5:1] !== 5'd1) begin
                bad++; $display("FAIL static_first u%0d got upds=%0d bin=%h delta=%h want 1/01/01",
                                k + 2, upds[k], obs_vec(k)[11:7], obs_vec(k)[5:1]);
            end
        end
    endtask

    task automatic test_wrap();
        int upds [2];
        upds = '{0, 0};
        gin = gray(29);
        repeat (8) @(negedge clk);
        for (int v = 30; v <= 33; v++) begin
            gin = gray(v % 32);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (obs_vec(k) !== exp_vec(k) || (obs_vec(k)[6] && obs_vec(k)[5:1] !== 5'd1)) begin
                        bad++; $display("FAIL wrap u%0d v%0d got %h want %h", k + 2, v, obs_vec(k), exp_vec(k));
                    end
                    upds[k] += int'(obs_vec(k)[6]);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (upds[k] != 4) begin
                bad++; $display("FAIL wrap_count u%0d got %0d want 4", k + 2, upds[k]);
            end
        end
    endtask

    task automatic test_catchup();
        int sum [2];
        sum = '{0, 0};
        gin = gray(5);
        repeat (8) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            if (c < 3) gin = gray(6 + c);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL catchup u%0d cyc%0d got %h want %h", k + 2, c, obs_vec(k), exp_vec(k));
                end
                if (obs_vec(k)[6]) sum[k] += int'(obs_vec(k)[5:1]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (sum[k] != 3 || obs_vec(k)[11:7] !== 5'd8) begin
                bad++; $display("FAIL catchup_sum u%0d got sum=%0d bin=%h want 3/08", k + 2, sum[k], obs_vec(k)[11:7]);
            end
        end
    endtask

    task automatic test_random();
        int cnt;
        cnt = 8;
        for (int c = 0; c < 300; c++) begin
            cnt += int'($urandom_range(0, 1));
            gin = gray(cnt);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL random u%0d cyc%0d got %h want %h", k + 2, c, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_err();
        rst = 1'b1; gin = '0; eclr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_vec(k)[0] !== 1'b0) begin
                bad++; $display("FAIL err_idle u%0d got %b want 0", k + 2, obs_vec(k)[0]);
            end
        end
        gin = 5'h03;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL err_jump u%0d cyc%0d got %h want %h", k + 2, c, obs_vec(k), exp_vec(k));
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_vec(k)[0] !== ERR_EN) begin
                bad++; $display("FAIL err_sticky u%0d got %b want %b", k + 2, obs_vec(k)[0], ERR_EN);
            end
        end
        eclr = 1'b1;
        @(negedge clk);
        eclr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_vec(k)[0] !== 1'b0 || obs_vec(k) !== exp_vec(k)) begin
                bad++; $display("FAIL err_clear u%0d got %h want %h", k + 2, obs_vec(k), exp_vec(k));
            end
        end
        rst = 1'b1; gin = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0; gin = 5'h03;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_vec(k)[0] !== 1'b0 || obs_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL err_unarmed u%0d cyc%0d got %h want %h", k + 2, c, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int upds [2];
        logic [PW-1:0] dl [2];
        upds = '{0, 0};
        dl[0] = '0; dl[1] = '0;
        gin = gray(9);
        repeat (8) @(negedge clk);
        gin = gray(10);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_vec(k) !== 17'd0) begin
                bad++; $display("FAIL reset_mid u%0d got %h want 0", k + 2, obs_vec(k));
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL refill u%0d cyc%0d got %h want %h", k + 2, c, obs_vec(k), exp_vec(k));
                end
                if (obs_vec(k)[6]) begin
                    upds[k]++;
                    dl[k] = obs_vec(k)[5:1];
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (upds[k] != 1 || dl[k] !== 5'd10) begin
                bad++; $display("FAIL refill_delta u%0d got upds=%0d delta=%h want 1/0a", k + 2, upds[k], dl[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_wrap();
        test_catchup();
        test_random();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
